// File: rtl/dfi_pkg.sv
// Shared types and constants for the DFI PHY init responder: FSM state encoding,
// default timing values and the 16-bit timer width.
package dfi_pkg;

    localparam int CNT_W   = 16;
    localparam int CNT_MAX = 65535;

    localparam logic [CNT_W-1:0] CNT_ZERO = 16'h0000;
    localparam logic [CNT_W-1:0] CNT_ONE  = 16'h0001;
    localparam logic [CNT_W-1:0] CNT_SAT  = 16'hFFFF;

    localparam int RESET_MIN_CYCLES_DEF = 200;
    localparam int TRAIN_CYCLES_DEF     = 1000;
    localparam int PHYUPD_INTERVAL_DEF  = 4096;

    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_IDLE       = 3'd1,
        ST_MEM_RESET  = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_TRAIN      = 3'd4,
        ST_COMPLETE   = 3'd5
    } dfi_state_e;

    // A timer loaded with 0 on entry shows this value on the final edge of a window of 'cycles' edges.
    function automatic logic [CNT_W-1:0] last_cycle_target(input int cycles);
        if (cycles <= 1) begin
            return CNT_ZERO;
        end else begin
            return CNT_W'(cycles - 1);
        end
    endfunction

endpackage

// File: rtl/dfi_cycle_timer.sv
// Saturating 16-bit cycle timer with synchronous load, count enable and a
// count >= target done flag.
module dfi_cycle_timer
    import dfi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Count register: load wins over enable, and the count sticks at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= load_val;
        end else if (enable && (count_r != CNT_SAT)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign done  = (count_r >= target);

endmodule

// File: rtl/dfi_phy_init_resp.sv
// DFI PHY-side init/training responder. Define DFI_PHYUPD_EN to enable periodic
// PHY update requests while in COMPLETE; otherwise dfi_phyupd_req is held at 0.
module dfi_phy_init_resp
    import dfi_pkg::*;
#(
    parameter int RESET_MIN_CYCLES = RESET_MIN_CYCLES_DEF,
    parameter int TRAIN_CYCLES     = TRAIN_CYCLES_DEF,
    parameter int PHYUPD_INTERVAL  = PHYUPD_INTERVAL_DEF
) (
    input  logic       core_clk,
    input  logic       core_arstn,
    input  logic       dfi_reset_n,
    input  logic       dfi_init_start,
    output logic       dfi_init_complete,
    output logic       dfi_phyupd_req,
    input  logic       dfi_phyupd_ack,
    output logic       reset_err,
    output logic [2:0] state_o
);

    if ((RESET_MIN_CYCLES < 0) || (RESET_MIN_CYCLES > CNT_MAX)) begin : g_bad_reset_min
        $error("RESET_MIN_CYCLES must be within 0..65535");
    end
    if ((TRAIN_CYCLES < 1) || (TRAIN_CYCLES > CNT_MAX)) begin : g_bad_train
        $error("TRAIN_CYCLES must be within 1..65535");
    end
    if ((PHYUPD_INTERVAL < 1) || (PHYUPD_INTERVAL > CNT_MAX)) begin : g_bad_phyupd
        $error("PHYUPD_INTERVAL must be within 1..65535");
    end

    localparam logic [CNT_W-1:0] RESET_TGT = CNT_W'(RESET_MIN_CYCLES);
    localparam logic [CNT_W-1:0] TRAIN_TGT = last_cycle_target(TRAIN_CYCLES);

    dfi_state_e       state_r;
    dfi_state_e       state_s;
    logic             start_q_r;
    logic             complete_r;
    logic             err_r;
    logic             err_set_s;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_load_val_s;
    logic             tmr_en_s;
    logic [CNT_W-1:0] tmr_target_s;
    logic             tmr_done_s;
    logic [CNT_W-1:0] tmr_count_unused_s;

    // Next-state and timer control; a low dfi_reset_n overrides every other input.
    always_comb begin
        state_s        = state_r;
        tmr_load_s     = 1'b0;
        tmr_load_val_s = CNT_ZERO;
        tmr_en_s       = 1'b0;
        err_set_s      = 1'b0;
        if (state_r == ST_MEM_RESET) begin
            tmr_target_s = RESET_TGT;
        end else begin
            tmr_target_s = TRAIN_TGT;
        end
        case (state_r)
            ST_RESET: begin
                state_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (!dfi_reset_n) begin
                    state_s        = ST_MEM_RESET;
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = CNT_ONE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MEM_RESET: begin
                // The entry edge already saw dfi_reset_n low, so the timer starts at 1.
                if (!dfi_reset_n) begin
                    tmr_en_s = 1'b1;
                end else if (tmr_done_s) begin
                    state_s = ST_WAIT_START;
                end else begin
                    state_s   = ST_IDLE;
                    err_set_s = 1'b1;
                end
            end
            ST_WAIT_START: begin
                if (!dfi_reset_n) begin
                    state_s        = ST_MEM_RESET;
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = CNT_ONE;
                end else if (dfi_init_start) begin
                    state_s    = ST_TRAIN;
                    tmr_load_s = 1'b1;
                end else begin
                    state_s = ST_WAIT_START;
                end
            end
            ST_TRAIN: begin
                if (!dfi_reset_n) begin
                    state_s        = ST_MEM_RESET;
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = CNT_ONE;
                end else if (!dfi_init_start) begin
                    state_s    = ST_WAIT_START;
                    tmr_load_s = 1'b1;
                end else if (tmr_done_s) begin
                    state_s = ST_COMPLETE;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            ST_COMPLETE: begin
                if (!dfi_reset_n) begin
                    state_s        = ST_MEM_RESET;
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = CNT_ONE;
                end else if (dfi_init_start && !start_q_r) begin
                    state_s    = ST_TRAIN;
                    tmr_load_s = 1'b1;
                end else begin
                    state_s = ST_COMPLETE;
                end
            end
            default: begin
                state_s = ST_RESET;
            end
        endcase
    end

    dfi_cycle_timer u_phase_timer (
        .clk      (core_clk),
        .rst_n    (core_arstn),
        .load     (tmr_load_s),
        .load_val (tmr_load_val_s),
        .enable   (tmr_en_s),
        .target   (tmr_target_s),
        .count    (tmr_count_unused_s),
        .done     (tmr_done_s)
    );

    // State, start-edge history, completion flag and sticky reset error.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            state_r    <= ST_RESET;
            start_q_r  <= 1'b0;
            complete_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            start_q_r  <= dfi_init_start;
            complete_r <= (state_s == ST_COMPLETE);
            err_r      <= err_r | err_set_s;
        end
    end

    assign dfi_init_complete = complete_r;
    assign reset_err         = err_r;
    assign state_o           = state_r;

`ifdef DFI_PHYUPD_EN
    localparam logic [CNT_W-1:0] UPD_TGT = last_cycle_target(PHYUPD_INTERVAL);

    logic             upd_req_r;
    logic             upd_req_s;
    logic             upd_load_s;
    logic             upd_en_s;
    logic             upd_done_s;
    logic [CNT_W-1:0] upd_count_unused_s;

    // Update interval runs only while staying in COMPLETE and freezes while a request is outstanding.
    always_comb begin
        upd_req_s  = 1'b0;
        upd_load_s = 1'b1;
        upd_en_s   = 1'b0;
        if ((state_r == ST_COMPLETE) && (state_s == ST_COMPLETE)) begin
            if (upd_req_r) begin
                if (dfi_phyupd_ack) begin
                    upd_req_s  = 1'b0;
                    upd_load_s = 1'b1;
                end else begin
                    upd_req_s  = 1'b1;
                    upd_load_s = 1'b0;
                end
            end else if (upd_done_s) begin
                upd_req_s  = 1'b1;
                upd_load_s = 1'b0;
            end else begin
                upd_load_s = 1'b0;
                upd_en_s   = 1'b1;
            end
        end else begin
            upd_req_s  = 1'b0;
            upd_load_s = 1'b1;
        end
    end

    dfi_cycle_timer u_upd_timer (
        .clk      (core_clk),
        .rst_n    (core_arstn),
        .load     (upd_load_s),
        .load_val (CNT_ZERO),
        .enable   (upd_en_s),
        .target   (UPD_TGT),
        .count    (upd_count_unused_s),
        .done     (upd_done_s)
    );

    // PHY update request register.
    always_ff @(posedge core_clk or negedge core_arstn) begin
        if (!core_arstn) begin
            upd_req_r <= 1'b0;
        end else begin
            upd_req_r <= upd_req_s;
        end
    end

    assign dfi_phyupd_req = upd_req_r;
`else
    logic unused_phyupd_ack_s;
    assign unused_phyupd_ack_s = dfi_phyupd_ack;
    assign dfi_phyupd_req      = 1'b0;
`endif

endmodule
